filter_sched: RTL and testbench
===============================

FILTER_SCHED -- requirements
Module: filter_sched

Interface
REQ-001 The block SHALL have parameters: IMG_W, default 28, input map width in pixels (min 5); IMG_H, default 28, input map height (min 5); DW, default 32, signed data width; AW, default 10, address width.
REQ-002 Clock and reset SHALL be: clk, in, 1, single clock with all logic on the rising edge; rst, in, 1, synchronous active-high reset.
REQ-003 Control ports SHALL be: start, in, 1, frame start pulse; busy, out, 1, high from the accepting cycle until done; done, out, 1, one-cycle end-of-frame pulse.
REQ-004 Read ports SHALL be: rd_en, out, 1, column read request; rd_row, out, AW, top row of the 5-row strip; rd_col, out, AW, column index; rd_data1..rd_data5, in, DW each, rows rd_row..rd_row+4, valid exactly 1 cycle after rd_en.
REQ-005 Filter-side ports SHALL be: d_in1..d_in5, out, DW each, column to the filter; filt_in_valid, out, 1; filt_d_out, in, DW, filter result; filt_out_valid, in, 1.
REQ-006 Write ports SHALL be: wr_en, out, 1; wr_addr, out, AW, output map address; wr_data, out, DW.

Function
REQ-007 The FSM SHALL have three states (IDLE, ISSUE, DRAIN) and SHALL transition IDLE->ISSUE on start, ISSUE->DRAIN after the last column of the last strip, and DRAIN->IDLE when every issued column has returned.
REQ-008 In ISSUE, rd_en SHALL be 1 every cycle with (rd_row, rd_col) stepping column-major within a strip: col 0..IMG_W-1, then row+1 and col 0, from row 0 to row IMG_H-5.
REQ-009 Total issued reads per frame SHALL be IMG_W*(IMG_H-4), with no idle cycles between strips.
REQ-010 d_in1..d_in5 SHALL equal rd_data1..rd_data5 registered, and filt_in_valid SHALL equal rd_en delayed by exactly 2 cycles (1 memory cycle plus 1 register).
REQ-011 A received counter SHALL count filt_out_valid pulses mod IMG_W per strip; pulses with index 0..3 SHALL be discarded (window not yet full) and the rest written.
REQ-012 For each kept pulse, wr_en SHALL be 1 in the next cycle, with wr_data = registered filt_d_out and wr_addr = out_row*(IMG_W-4)+out_col; wr_addr SHALL start at 0 and increment by 1 per write.
REQ-013 Writes per frame SHALL total (IMG_W-4)*(IMG_H-4), and the final write SHALL occur in the cycle before done.
REQ-014 done SHALL pulse for 1 cycle when the received count reaches the issued count, and busy SHALL fall in the same cycle that done rises.
REQ-015 start while busy SHALL be ignored; start in the same cycle as done SHALL be ignored; filt_out_valid while IDLE SHALL be ignored and SHALL NOT be counted.
REQ-016 Address arithmetic SHALL be unsigned; out_col SHALL wrap to 0 and out_row SHALL increment at IMG_W-4.
REQ-017 There SHALL be no backpressure: the filter and the write sink SHALL accept one item per cycle.

Reset
REQ-018 rst SHALL force IDLE and zero all counters and outputs: busy, done, rd_en, rd_row, rd_col, d_in1..5, filt_in_valid, wr_en, wr_addr, wr_data.
REQ-019 rst asserted mid-frame SHALL abort the frame without asserting done, and filt_out_valid pulses still in flight after reset SHALL be ignored.

Configuration
REQ-020 With FILTER_SCHED_RELU_EN defined, wr_data SHALL be 0 whenever filt_d_out is negative (sign bit set) and filt_d_out otherwise; without the macro, wr_data SHALL equal filt_d_out unmodified.

Verification
REQ-021 Setup: IMG_W=8, IMG_H=6; start pulse -> 16 consecutive rd_en cycles with (row,col) = (0,0)..(0,7),(1,0)..(1,7), and filt_in_valid asserted 2 cycles after each rd_en.
REQ-022 Filter model with 3-cycle latency echoing d_in1 -> exactly 8 writes at wr_addr 0..7 with data from cols 4..7 of each strip, then a 1-cycle done and busy=0.
REQ-023 Bench drives start while busy and filt_out_valid in IDLE -> no restart, no extra writes, and count unchanged.
REQ-024 rst asserted in cycle 5 of ISSUE -> all outputs 0 next cycle and no done; a new start then yields a full correct frame.
REQ-025 With FILTER_SCHED_RELU_EN, filt_d_out=32'hFFFFFFFB -> wr_data=0; filt_d_out=32'h00000032 -> wr_data=32'h00000032. Without the macro, 32'hFFFFFFFB passes unchanged.
REQ-026 Back-to-back frames with start one cycle after done -> two complete frames with wr_addr restarting at 0.

Source files
------------

// File: rtl/filter_sched.sv
// Strip-mining scheduler for a 5x5 filter: streams 5-row columns to the filter and writes back valid outputs.
// Optional FILTER_SCHED_RELU_EN clamps negative filter results to zero on write.
module filter_sched #(
    parameter int unsigned IMG_W = 28,
    parameter int unsigned IMG_H = 28,
    parameter int unsigned DW    = 32,
    parameter int unsigned AW    = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          rd_en,
    output logic [AW-1:0] rd_row,
    output logic [AW-1:0] rd_col,
    input  logic [DW-1:0] rd_data1,
    input  logic [DW-1:0] rd_data2,
    input  logic [DW-1:0] rd_data3,
    input  logic [DW-1:0] rd_data4,
    input  logic [DW-1:0] rd_data5,
    output logic [DW-1:0] d_in1,
    output logic [DW-1:0] d_in2,
    output logic [DW-1:0] d_in3,
    output logic [DW-1:0] d_in4,
    output logic [DW-1:0] d_in5,
    output logic          filt_in_valid,
    input  logic [DW-1:0] filt_d_out,
    input  logic          filt_out_valid,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data
);

    localparam int unsigned TOTAL = IMG_W * (IMG_H - 4);
    localparam int unsigned CW    = $clog2(TOTAL + 1);
    localparam int unsigned XW    = $clog2(IMG_W);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t          state_q, state_n;
    logic            busy_n, done_n, rd_en_n, wr_en_n;
    logic [AW-1:0]   rd_row_n, rd_col_n, wr_addr_n;
    logic [DW-1:0]   wr_data_n, res_data;
    logic            rd_en_d1;
    logic [XW-1:0]   recv_col, recv_col_n, out_col, out_col_n;
    logic [CW-1:0]   recv_cnt, recv_cnt_n;
    logic [AW-1:0]   row_base, row_base_n;

`ifdef FILTER_SCHED_RELU_EN
    assign res_data = filt_d_out[DW-1] ? '0 : filt_d_out;
`else
    assign res_data = filt_d_out;
`endif

    // Next-state, issue sequencing and write-back bookkeeping
    always_comb begin
        state_n    = state_q;
        busy_n     = busy;
        done_n     = 1'b0;
        rd_en_n    = 1'b0;
        rd_row_n   = rd_row;
        rd_col_n   = rd_col;
        recv_col_n = recv_col;
        recv_cnt_n = recv_cnt;
        out_col_n  = out_col;
        row_base_n = row_base;
        wr_en_n    = 1'b0;
        wr_addr_n  = wr_addr;
        wr_data_n  = wr_data;

        case (state_q)
            IDLE: begin
                // a start coinciding with done belongs to the finished frame and is dropped
                if (start && !done) begin
                    state_n    = ISSUE;
                    busy_n     = 1'b1;
                    rd_en_n    = 1'b1;
                    rd_row_n   = '0;
                    rd_col_n   = '0;
                    recv_col_n = '0;
                    recv_cnt_n = '0;
                    out_col_n  = '0;
                    row_base_n = '0;
                end
            end
            ISSUE: begin
                if (rd_col == AW'(IMG_W - 1)) begin
                    rd_col_n = '0;
                    if (rd_row == AW'(IMG_H - 5)) begin
                        state_n = DRAIN;
                    end else begin
                        rd_row_n = rd_row + AW'(1);
                        rd_en_n  = 1'b1;
                    end
                end else begin
                    rd_col_n = rd_col + AW'(1);
                    rd_en_n  = 1'b1;
                end
            end
            DRAIN: begin
                if (recv_cnt == CW'(TOTAL)) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase

        // First four results of each strip come from a partially filled window
        if (state_q != IDLE && filt_out_valid && recv_cnt != CW'(TOTAL)) begin
            recv_cnt_n = recv_cnt + CW'(1);
            recv_col_n = (recv_col == XW'(IMG_W - 1)) ? '0 : recv_col + XW'(1);
            if (recv_col >= XW'(4)) begin
                wr_en_n   = 1'b1;
                wr_data_n = res_data;
                wr_addr_n = row_base + AW'(out_col);
                if (out_col == XW'(IMG_W - 5)) begin
                    out_col_n  = '0;
                    row_base_n = row_base + AW'(IMG_W - 4);
                end else begin
                    out_col_n = out_col + XW'(1);
                end
            end
        end
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            rd_en         <= 1'b0;
            rd_row        <= '0;
            rd_col        <= '0;
            rd_en_d1      <= 1'b0;
            filt_in_valid <= 1'b0;
            d_in1         <= '0;
            d_in2         <= '0;
            d_in3         <= '0;
            d_in4         <= '0;
            d_in5         <= '0;
            recv_col      <= '0;
            recv_cnt      <= '0;
            out_col       <= '0;
            row_base      <= '0;
            wr_en         <= 1'b0;
            wr_addr       <= '0;
            wr_data       <= '0;
        end else begin
            state_q       <= state_n;
            busy          <= busy_n;
            done          <= done_n;
            rd_en         <= rd_en_n;
            rd_row        <= rd_row_n;
            rd_col        <= rd_col_n;
            rd_en_d1      <= rd_en;
            filt_in_valid <= rd_en_d1;
            d_in1         <= rd_data1;
            d_in2         <= rd_data2;
            d_in3         <= rd_data3;
            d_in4         <= rd_data4;
            d_in5         <= rd_data5;
            recv_col      <= recv_col_n;
            recv_cnt      <= recv_cnt_n;
            out_col       <= out_col_n;
            row_base      <= row_base_n;
            wr_en         <= wr_en_n;
            wr_addr       <= wr_addr_n;
            wr_data       <= wr_data_n;
        end
    end

endmodule

// File: tb/tb_filter_sched.sv
// Directed bench for filter_sched on an 8x6 map with a memory model and a 3-cycle echo filter.
module tb_filter_sched;

    localparam int unsigned IMG_W = 8;
    localparam int unsigned IMG_H = 6;
    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 10;

    logic          clk = 1'b0;
    logic          rst, start;
    logic          busy, done, rd_en, filt_in_valid, wr_en;
    logic [AW-1:0] rd_row, rd_col, wr_addr;
    logic [DW-1:0] rd_data1 = '0, rd_data2 = '0, rd_data3 = '0, rd_data4 = '0, rd_data5 = '0;
    logic [DW-1:0] d_in1, d_in2, d_in3, d_in4, d_in5, wr_data;
    logic [DW-1:0] filt_d_out;
    logic          filt_out_valid;

    logic          filt_en, inj_v;
    logic [DW-1:0] inj_d;
    logic [2:0]    fv = '0;
    logic [DW-1:0] fd0 = '0, fd1 = '0, fd2 = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int s_cyc;
    bit ok;

    int rd_row_q[$], rd_col_q[$], rd_cyc_q[$];
    int fiv_cyc_q[$];
    logic [DW-1:0] fiv_d1_q[$], fiv_d5_q[$];
    int wr_addr_q[$], wr_cyc_q[$];
    logic [DW-1:0] wr_data_q[$];
    int done_cyc_q[$];
    logic done_busy_q[$];

    logic [DW-1:0] relu_tbl [16] = '{
        32'hDEAD0000, 32'hDEAD0001, 32'hDEAD0002, 32'hDEAD0003,
        32'hFFFFFFFB, 32'h00000032, 32'h80000000, 32'h7FFFFFFF,
        32'hDEAD0008, 32'hDEAD0009, 32'hDEAD000A, 32'hDEAD000B,
        32'hFFFFFFFF, 32'h00000000, 32'h00000001, 32'h12345678};

    filter_sched #(.IMG_W(IMG_W), .IMG_H(IMG_H), .DW(DW), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col),
        .rd_data1(rd_data1), .rd_data2(rd_data2), .rd_data3(rd_data3),
        .rd_data4(rd_data4), .rd_data5(rd_data5),
        .d_in1(d_in1), .d_in2(d_in2), .d_in3(d_in3), .d_in4(d_in4), .d_in5(d_in5),
        .filt_in_valid(filt_in_valid), .filt_d_out(filt_d_out),
        .filt_out_valid(filt_out_valid),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    // Pixel (r, c) holds {r, c} so every column element is traceable
    function automatic logic [DW-1:0] mem(input int r, input int c, input int k);
        return DW'(((r + k) << 12) | c);
    endfunction

    function automatic logic [DW-1:0] relu_exp(input logic [DW-1:0] v);
`ifdef FILTER_SCHED_RELU_EN
        return v[DW-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rd_en) begin
            rd_data1 <= mem(int'(rd_row), int'(rd_col), 0);
            rd_data2 <= mem(int'(rd_row), int'(rd_col), 1);
            rd_data3 <= mem(int'(rd_row), int'(rd_col), 2);
            rd_data4 <= mem(int'(rd_row), int'(rd_col), 3);
            rd_data5 <= mem(int'(rd_row), int'(rd_col), 4);
        end
        fv  <= {fv[1:0], filt_in_valid & filt_en};
        fd0 <= d_in1;
        fd1 <= fd0;
        fd2 <= fd1;
    end

    assign filt_out_valid = fv[2] | inj_v;
    assign filt_d_out     = inj_v ? inj_d : fd2;

    always @(negedge clk) begin
        if (rd_en) begin
            rd_row_q.push_back(int'(rd_row));
            rd_col_q.push_back(int'(rd_col));
            rd_cyc_q.push_back(cyc);
        end
        if (filt_in_valid) begin
            fiv_cyc_q.push_back(cyc);
            fiv_d1_q.push_back(d_in1);
            fiv_d5_q.push_back(d_in5);
        end
        if (wr_en) begin
            wr_addr_q.push_back(int'(wr_addr));
            wr_data_q.push_back(wr_data);
            wr_cyc_q.push_back(cyc);
        end
        if (done) begin
            done_cyc_q.push_back(cyc);
            done_busy_q.push_back(busy);
        end
    end

    task automatic clear_logs();
        rd_row_q.delete(); rd_col_q.delete(); rd_cyc_q.delete();
        fiv_cyc_q.delete(); fiv_d1_q.delete(); fiv_d5_q.delete();
        wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
        done_cyc_q.delete(); done_busy_q.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        s_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output bit got);
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(2);
        checks++;
        if ({busy, done, rd_en, filt_in_valid, wr_en} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: busy/done/rd_en/fiv/wr_en=%b expected 00000",
                     {busy, done, rd_en, filt_in_valid, wr_en});
        end
        checks++;
        if (rd_row !== '0 || rd_col !== '0 || wr_addr !== '0) begin
            errors++;
            $display("FAIL reset_addr: rd_row=%0d rd_col=%0d wr_addr=%0d expected 0", rd_row, rd_col, wr_addr);
        end
        checks++;
        if ((d_in1 | d_in2 | d_in3 | d_in4 | d_in5 | wr_data) !== '0) begin
            errors++;
            $display("FAIL reset_data: d_in/wr_data not zero (d_in1=%h wr_data=%h)", d_in1, wr_data);
        end
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_frame();
        clear_logs();
        pulse_start();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL frame_busy: busy=%b expected 1", busy);
        end
        wait_done(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL frame_timeout: done=0 expected 1 within 200 cycles");
        end
        idle(5);
        checks++;
        if (rd_cyc_q.size() !== 16) begin
            errors++;
            $display("FAIL frame_rd_count: got %0d expected 16", rd_cyc_q.size());
        end
        for (int i = 0; i < rd_cyc_q.size() && i < 16; i++) begin
            checks++;
            if (rd_row_q[i] !== i / 8 || rd_col_q[i] !== i % 8 || rd_cyc_q[i] !== s_cyc + 1 + i) begin
                errors++;
                $display("FAIL frame_rd[%0d]: row=%0d col=%0d cyc=%0d expected row=%0d col=%0d cyc=%0d",
                         i, rd_row_q[i], rd_col_q[i], rd_cyc_q[i], i / 8, i % 8, s_cyc + 1 + i);
            end
        end
        checks++;
        if (fiv_cyc_q.size() !== 16) begin
            errors++;
            $display("FAIL frame_fiv_count: got %0d expected 16", fiv_cyc_q.size());
        end
        for (int i = 0; i < fiv_cyc_q.size() && i < 16; i++) begin
            checks++;
            if (fiv_cyc_q[i] !== s_cyc + 3 + i || fiv_d1_q[i] !== mem(i / 8, i % 8, 0)
                || fiv_d5_q[i] !== mem(i / 8, i % 8, 4)) begin
                errors++;
                $display("FAIL frame_fiv[%0d]: cyc=%0d d1=%h d5=%h expected cyc=%0d d1=%h d5=%h",
                         i, fiv_cyc_q[i], fiv_d1_q[i], fiv_d5_q[i], s_cyc + 3 + i,
                         mem(i / 8, i % 8, 0), mem(i / 8, i % 8, 4));
            end
        end
        checks++;
        if (wr_addr_q.size() !== 8) begin
            errors++;
            $display("FAIL frame_wr_count: got %0d expected 8", wr_addr_q.size());
        end
        for (int i = 0; i < wr_addr_q.size() && i < 8; i++) begin
            checks++;
            if (wr_addr_q[i] !== i || wr_data_q[i] !== mem(i / 4, 4 + i % 4, 0)) begin
                errors++;
                $display("FAIL frame_wr[%0d]: addr=%0d data=%h expected addr=%0d data=%h",
                         i, wr_addr_q[i], wr_data_q[i], i, mem(i / 4, 4 + i % 4, 0));
            end
        end
        checks++;
        if (done_cyc_q.size() !== 1) begin
            errors++;
            $display("FAIL frame_done_count: got %0d expected 1", done_cyc_q.size());
        end else begin
            checks++;
            if (done_cyc_q[0] !== s_cyc + 23 || done_busy_q[0] !== 1'b0) begin
                errors++;
                $display("FAIL frame_done_timing: cyc=%0d busy=%b expected cyc=%0d busy=0",
                         done_cyc_q[0], done_busy_q[0], s_cyc + 23);
            end
        end
        if (wr_cyc_q.size() == 8 && done_cyc_q.size() == 1) begin
            checks++;
            if (wr_cyc_q[7] !== s_cyc + 22) begin
                errors++;
                $display("FAIL frame_last_wr: cyc=%0d expected %0d", wr_cyc_q[7], s_cyc + 22);
            end
        end
    endtask

    task automatic test_ignore();
        clear_logs();
        start = 1'b1;
        s_cyc = cyc;
        @(negedge clk);
        wait_done(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL ignore_timeout: done=0 expected 1 within 200 cycles");
        end
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (busy !== 1'b0 || rd_en !== 1'b0) begin
                errors++;
                $display("FAIL ignore_restart[%0d]: busy=%b rd_en=%b expected 0 0", i, busy, rd_en);
            end
            @(negedge clk);
        end
        checks++;
        if (rd_cyc_q.size() !== 16 || wr_addr_q.size() !== 8 || done_cyc_q.size() !== 1) begin
            errors++;
            $display("FAIL ignore_counts: rd=%0d wr=%0d done=%0d expected 16 8 1",
                     rd_cyc_q.size(), wr_addr_q.size(), done_cyc_q.size());
        end
        inj_d = 32'h0000_0055;
        inj_v = 1'b1;
        idle(6);
        inj_v = 1'b0;
        idle(6);
        checks++;
        if (wr_addr_q.size() !== 8 || busy !== 1'b0 || done_cyc_q.size() !== 1) begin
            errors++;
            $display("FAIL ignore_idle_valid: wr=%0d busy=%b done=%0d expected 8 0 1",
                     wr_addr_q.size(), busy, done_cyc_q.size());
        end
        clear_logs();
        pulse_start();
        wait_done(ok);
        idle(3);
        checks++;
        if (!ok || done_cyc_q.size() !== 1 || done_cyc_q[0] !== s_cyc + 23) begin
            errors++;
            $display("FAIL ignore_next_done: seen=%0d expected done at cycle %0d", done_cyc_q.size(), s_cyc + 23);
        end
        for (int i = 0; i < wr_addr_q.size() && i < 8; i++) begin
            checks++;
            if (wr_addr_q[i] !== i || wr_data_q[i] !== mem(i / 4, 4 + i % 4, 0)) begin
                errors++;
                $display("FAIL ignore_next_wr[%0d]: addr=%0d data=%h expected addr=%0d data=%h",
                         i, wr_addr_q[i], wr_data_q[i], i, mem(i / 4, 4 + i % 4, 0));
            end
        end
    endtask

    task automatic test_reset_mid();
        clear_logs();
        pulse_start();
        idle(4);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, rd_en, filt_in_valid, wr_en} !== 5'b0 || rd_row !== '0 || rd_col !== '0
            || wr_addr !== '0 || d_in1 !== '0 || d_in5 !== '0 || wr_data !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: busy=%b rd_en=%b fiv=%b rd_col=%0d d_in1=%h expected all 0",
                     busy, rd_en, filt_in_valid, rd_col, d_in1);
        end
        rst = 1'b0;
        idle(20);
        checks++;
        if (done_cyc_q.size() !== 0 || wr_addr_q.size() !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_abort: done=%0d wr=%0d busy=%b expected 0 0 0",
                     done_cyc_q.size(), wr_addr_q.size(), busy);
        end
        clear_logs();
        pulse_start();
        wait_done(ok);
        idle(3);
        checks++;
        if (!ok || wr_addr_q.size() !== 8 || rd_cyc_q.size() !== 16) begin
            errors++;
            $display("FAIL midreset_frame: wr=%0d rd=%0d expected 8 16", wr_addr_q.size(), rd_cyc_q.size());
        end
        for (int i = 0; i < wr_addr_q.size() && i < 8; i++) begin
            checks++;
            if (wr_addr_q[i] !== i || wr_data_q[i] !== mem(i / 4, 4 + i % 4, 0)) begin
                errors++;
                $display("FAIL midreset_wr[%0d]: addr=%0d data=%h expected addr=%0d data=%h",
                         i, wr_addr_q[i], wr_data_q[i], i, mem(i / 4, 4 + i % 4, 0));
            end
        end
    endtask

    task automatic test_relu();
        clear_logs();
        filt_en = 1'b0;
        pulse_start();
        for (int i = 0; i < 16; i++) begin
            inj_v = 1'b1;
            inj_d = relu_tbl[i];
            @(negedge clk);
        end
        inj_v = 1'b0;
        wait_done(ok);
        idle(3);
        filt_en = 1'b1;
        checks++;
        if (!ok || wr_addr_q.size() !== 8) begin
            errors++;
            $display("FAIL relu_count: wr=%0d expected 8", wr_addr_q.size());
        end
        for (int i = 0; i < wr_addr_q.size() && i < 8; i++) begin
            checks++;
            if (wr_addr_q[i] !== i || wr_data_q[i] !== relu_exp(relu_tbl[(i / 4) * 8 + 4 + i % 4])) begin
                errors++;
                $display("FAIL relu_wr[%0d]: addr=%0d data=%h expected addr=%0d data=%h",
                         i, wr_addr_q[i], wr_data_q[i], i, relu_exp(relu_tbl[(i / 4) * 8 + 4 + i % 4]));
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_logs();
        pulse_start();
        wait_done(ok);
        @(negedge clk);
        pulse_start();
        checks++;
        if (!ok || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second_start: busy=%b expected 1", busy);
        end
        wait_done(ok);
        idle(3);
        checks++;
        if (!ok || rd_cyc_q.size() !== 32 || wr_addr_q.size() !== 16 || done_cyc_q.size() !== 2) begin
            errors++;
            $display("FAIL b2b_counts: rd=%0d wr=%0d done=%0d expected 32 16 2",
                     rd_cyc_q.size(), wr_addr_q.size(), done_cyc_q.size());
        end
        for (int i = 0; i < wr_addr_q.size() && i < 16; i++) begin
            checks++;
            if (wr_addr_q[i] !== i % 8 || wr_data_q[i] !== mem((i % 8) / 4, 4 + i % 4, 0)) begin
                errors++;
                $display("FAIL b2b_wr[%0d]: addr=%0d data=%h expected addr=%0d data=%h",
                         i, wr_addr_q[i], wr_data_q[i], i % 8, mem((i % 8) / 4, 4 + i % 4, 0));
            end
        end
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        filt_en = 1'b1;
        inj_v   = 1'b0;
        inj_d   = '0;
        @(negedge clk);
        test_reset();
        test_frame();
        test_ignore();
        test_reset_mid();
        test_relu();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
